// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between 4x-upscaled scan-out and a pixel writer.
// Optional feature: define FB_STALL_CNT_EN to add the STALL_CNT writer-stall counter output.
module vga_fb_arbiter #(
   parameter int FB_W = 160,
   parameter int FB_H = 120,
   parameter int AW   = 15
) (
   input  logic          CLK_25MHz,
   input  logic          RESET_N,
   input  logic [9:0]    CURX,
   input  logic [8:0]    CURY,
   input  logic          HBLANK,
   input  logic          VBLANK,
   output logic [7:0]    COLOR_OUT,
   output logic          FRAME_START,
   input  logic          WR_REQ,
   input  logic [AW-1:0] WR_ADDR,
   input  logic [7:0]    WR_DATA,
   output logic          WR_ACK,
   output logic [AW-1:0] RAM_ADDR,
   output logic          RAM_WE,
   output logic [7:0]    RAM_WDATA,
`ifdef FB_STALL_CNT_EN
   output logic [15:0]   STALL_CNT,
`endif
   input  logic [7:0]    RAM_RDATA
);

   localparam int FB_SIZE = FB_W * FB_H;

   logic [7:0]    cur_q;
   logic [7:0]    nxt_q;
   logic [7:0]    bcnt;
   logic          cap_cur;
   logic          cap_nxt;
   logic          line_ok;
   logic          vblank_q;
   logic          frame_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    wdata_q;

   logic [7:0]    grp;
   logic [6:0]    row;
   logic [8:0]    col_next;
   logic [8:0]    rd_col;
   logic [AW-1:0] rd_addr;
   logic          pre0;
   logic          pre1;
   logic          phase3;
   logic          line_rd;
   logic          rd_en;
   logic          in_range;
   logic          unused;

   assign grp      = CURX[9:2];
   assign row      = CURY[8:2];
   assign col_next = {1'b0, grp} + 9'd2;
   assign unused   = &{1'b0, CURY[1:0]};

   assign pre0     = !VBLANK && (bcnt == 8'd64);
   assign pre1     = !VBLANK && (bcnt == 8'd65);
   assign phase3   = !VBLANK && !HBLANK && (CURX[1:0] == 2'd3);
   assign line_rd  = phase3 && (int'(col_next) < FB_W);
   assign rd_en    = pre0 || pre1 || line_rd;
   assign in_range = int'(WR_ADDR) < FB_SIZE;

   always_comb begin
      rd_col = col_next;
      if (pre0)
         rd_col = 9'd0;
      else if (pre1)
         rd_col = 9'd1;
   end

   assign rd_addr = AW'(int'(row) * FB_W + int'(rd_col));

   // Outputs are combinational, so force reset values while RESET_N is low.
   always_comb begin
      RAM_ADDR  = addr_q;
      RAM_WDATA = wdata_q;
      RAM_WE    = 1'b0;
      WR_ACK    = 1'b0;
      if (!RESET_N) begin
         RAM_ADDR  = '0;
         RAM_WDATA = '0;
      end else if (rd_en) begin
         RAM_ADDR = rd_addr;
      end else if (WR_REQ) begin
         RAM_ADDR  = WR_ADDR;
         RAM_WDATA = WR_DATA;
         WR_ACK    = 1'b1;
         RAM_WE    = in_range;
      end
   end

   // line_ok stays low after a reset until the next blank prefetch, so a
   // line interrupted by reset keeps showing colour 0 to its end.
   always_ff @(posedge CLK_25MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         cur_q    <= '0;
         nxt_q    <= '0;
         bcnt     <= '0;
         cap_cur  <= 1'b0;
         cap_nxt  <= 1'b0;
         line_ok  <= 1'b0;
         vblank_q <= 1'b0;
         frame_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         if (!HBLANK)
            bcnt <= '0;
         else if (bcnt != 8'hFF)
            bcnt <= bcnt + 8'd1;
         cap_cur <= pre0;
         cap_nxt <= pre1 || (line_rd && line_ok);
         if (pre1)
            line_ok <= 1'b1;
         if (cap_cur)
            cur_q <= RAM_RDATA;
         else if (phase3)
            cur_q <= nxt_q;
         if (cap_nxt)
            nxt_q <= RAM_RDATA;
         vblank_q <= VBLANK;
         frame_q  <= VBLANK && !vblank_q;
         addr_q   <= RAM_ADDR;
         wdata_q  <= RAM_WDATA;
      end
   end

   assign COLOR_OUT   = cur_q;
   assign FRAME_START = frame_q;

`ifdef FB_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge CLK_25MHz or negedge RESET_N) begin
      if (!RESET_N)
         stall_q <= '0;
      else if (frame_q)
         stall_q <= '0;
      else if (WR_REQ && !WR_ACK && (stall_q != 16'hFFFF))
         stall_q <= stall_q + 16'd1;
   end

   assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural synchronous RAM.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  curx;
   logic [8:0]  cury;
   logic        hblank;
   logic        vblank;
   logic [7:0]  color_out;
   logic        frame_start;
   logic        wr_req;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
`ifdef FB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   logic        n_req;
   logic [14:0] n_addr;
   logic [7:0]  n_data;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [0:32767];

   always #5 clk = ~clk;

   vga_fb_arbiter #(.FB_W(160), .FB_H(120), .AW(15)) dut (
      .CLK_25MHz   (clk),
      .RESET_N     (rst_n),
      .CURX        (curx),
      .CURY        (cury),
      .HBLANK      (hblank),
      .VBLANK      (vblank),
      .COLOR_OUT   (color_out),
      .FRAME_START (frame_start),
      .WR_REQ      (wr_req),
      .WR_ADDR     (wr_addr),
      .WR_DATA     (wr_data),
      .WR_ACK      (wr_ack),
      .RAM_ADDR    (ram_addr),
      .RAM_WE      (ram_we),
      .RAM_WDATA   (ram_wdata),
`ifdef FB_STALL_CNT_EN
      .STALL_CNT   (stall_cnt),
`endif
      .RAM_RDATA   (ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   function automatic logic [7:0] pix(input int r, input int k);
      case (r)
         0:       return 8'(k);
         1:       return 8'(255 - k);
         default: return 8'(k ^ 'hC3);
      endcase
   endfunction

   // One clock: apply inputs just after the edge, return at the falling edge for checking.
   task automatic cyc(input int x, input int y, input logic hb, input logic vb);
      @(posedge clk);
      #1;
      curx    = 10'(x);
      cury    = 9'(y);
      hblank  = hb;
      vblank  = vb;
      wr_req  = n_req;
      wr_addr = n_addr;
      wr_data = n_data;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_req  = 1'b1;
      n_addr = 15'd5;
      n_data = 8'h7F;
      cyc(0, 0, 1'b1, 1'b1);
      vectors++;
      if ({color_out, frame_start, ram_we, wr_ack, ram_addr, ram_wdata} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got col=%h fs=%b we=%b ack=%b addr=%0d wd=%h want all zero",
                  color_out, frame_start, ram_we, wr_ack, ram_addr, ram_wdata);
      end
`ifdef FB_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_stall got %0d want 0", stall_cnt);
      end
`endif
      rst_n = 1'b1;
      n_req = 1'b0;
      cyc(0, 0, 1'b1, 1'b1);
   endtask

   task automatic test_vblank_write();
      n_req  = 1'b1;
      n_addr = 15'd0;
      n_data = 8'hA5;
      cyc(0, 0, 1'b1, 1'b1);
      vectors++;
      if ({wr_ack, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'd0, 8'hA5}) begin
         miscompares++;
         $display("FAIL vblank_write got ack=%b we=%b addr=%0d wd=%h want ack=1 we=1 addr=0 wd=a5",
                  wr_ack, ram_we, ram_addr, ram_wdata);
      end
      // Back-to-back preload of rows 0..2 through the writer port.
      for (int a = 0; a < 480; a++) begin
         n_addr = 15'(a);
         n_data = pix(a / 160, a % 160);
         cyc(0, 0, 1'b1, 1'b1);
         vectors++;
         if ({wr_ack, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, n_addr, n_data}) begin
            miscompares++;
            $display("FAIL preload_write a=%0d got ack=%b we=%b addr=%0d wd=%h want ack=1 we=1 addr=%0d wd=%h",
                     a, wr_ack, ram_we, ram_addr, ram_wdata, n_addr, n_data);
         end
      end
      n_req = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [14:0] addrs [3];
      logic        we_exp [3];
      addrs  = '{15'd19199, 15'd19200, 15'd32767};
      we_exp = '{1'b1, 1'b0, 1'b0};
      n_data = 8'h5C;
      for (int i = 0; i < 3; i++) begin
         n_req  = 1'b1;
         n_addr = addrs[i];
         cyc(0, 0, 1'b1, 1'b1);
         vectors++;
         if ({wr_ack, ram_we, ram_addr} !== {1'b1, we_exp[i], addrs[i]}) begin
            miscompares++;
            $display("FAIL range_write addr=%0d got ack=%b we=%b ram_addr=%0d want ack=1 we=%b",
                     addrs[i], wr_ack, ram_we, ram_addr, we_exp[i]);
         end
      end
      n_req = 1'b0;
      cyc(0, 0, 1'b1, 1'b1);
      vectors++;
      if ({wr_ack, ram_we, ram_addr} !== {1'b0, 1'b0, 15'd32767}) begin
         miscompares++;
         $display("FAIL idle_hold got ack=%b we=%b addr=%0d want ack=0 we=0 addr=32767",
                  wr_ack, ram_we, ram_addr);
      end
   endtask

   task automatic test_scanout();
      n_req = 1'b0;
      cyc(0, 0, 1'b0, 1'b1);
      for (int y = 0; y < 4; y++) begin
         for (int i = 0; i < 160; i++)
            cyc(0, y, 1'b1, 1'b0);
         for (int x = 0; x < 640; x++) begin
            cyc(x, y, 1'b0, 1'b0);
            vectors++;
            if (color_out !== pix(0, x >> 2)) begin
               miscompares++;
               $display("FAIL scanout y=%0d x=%0d got %h want %h", y, x, color_out, pix(0, x >> 2));
            end
         end
      end
   endtask

   task automatic test_reset_midline();
      for (int i = 0; i < 160; i++)
         cyc(0, 8, 1'b1, 1'b0);
      for (int x = 0; x < 198; x++) begin
         cyc(x, 8, 1'b0, 1'b0);
         vectors++;
         if (color_out !== pix(2, x >> 2)) begin
            miscompares++;
            $display("FAIL row2_scan x=%0d got %h want %h", x, color_out, pix(2, x >> 2));
         end
      end
      n_req  = 1'b1;
      n_addr = 15'd777;
      n_data = 8'h11;
      cyc(198, 8, 1'b0, 1'b0);
      vectors++;
      if ({wr_ack, ram_addr, color_out} !== {1'b1, 15'd777, pix(2, 49)}) begin
         miscompares++;
         $display("FAIL pre_reset got ack=%b addr=%0d col=%h want ack=1 addr=777 col=%h",
                  wr_ack, ram_addr, color_out, pix(2, 49));
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({color_out, frame_start, ram_we, wr_ack, ram_addr, ram_wdata} !== 35'd0) begin
         miscompares++;
         $display("FAIL midline_reset got col=%h fs=%b we=%b ack=%b addr=%0d wd=%h want all zero",
                  color_out, frame_start, ram_we, wr_ack, ram_addr, ram_wdata);
      end
      n_req  = 1'b0;
      wr_req = 1'b0;
      cyc(199, 8, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int x = 200; x < 640; x++) begin
         cyc(x, 8, 1'b0, 1'b0);
         vectors++;
         if (color_out !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_black x=%0d got %h want 00", x, color_out);
         end
      end
      for (int i = 0; i < 160; i++)
         cyc(0, 9, 1'b1, 1'b0);
      for (int x = 0; x < 640; x++) begin
         cyc(x, 9, 1'b0, 1'b0);
         vectors++;
         if (color_out !== pix(2, x >> 2)) begin
            miscompares++;
            $display("FAIL recover_line x=%0d got %h want %h", x, color_out, pix(2, x >> 2));
         end
      end
   endtask

   task automatic test_contention();
      logic        exp_ack;
      logic [14:0] exp_addr;
      int          g;
      n_req  = 1'b1;
      n_addr = 15'd19000;
      n_data = 8'h3C;
      for (int i = 0; i < 160; i++) begin
         cyc(0, 4, 1'b1, 1'b0);
         exp_ack  = !(i == 64 || i == 65);
         exp_addr = exp_ack ? 15'd19000 : 15'(160 + i - 64);
         vectors++;
         if ({wr_ack, ram_we, ram_addr} !== {exp_ack, exp_ack, exp_addr}) begin
            miscompares++;
            $display("FAIL blank_slot i=%0d got ack=%b we=%b addr=%0d want ack=%b we=%b addr=%0d",
                     i, wr_ack, ram_we, ram_addr, exp_ack, exp_ack, exp_addr);
         end
      end
      for (int x = 0; x < 640; x++) begin
         cyc(x, 4, 1'b0, 1'b0);
         g        = x >> 2;
         exp_ack  = !((x % 4 == 3) && (g < 158));
         exp_addr = exp_ack ? 15'd19000 : 15'(160 + g + 2);
         vectors++;
         if ({wr_ack, ram_we, ram_addr} !== {exp_ack, exp_ack, exp_addr}) begin
            miscompares++;
            $display("FAIL %s x=%0d got ack=%b we=%b addr=%0d want ack=%b we=%b addr=%0d",
                     (g >= 158 && x % 4 == 3) ? "eol_slot" : "line_slot",
                     x, wr_ack, ram_we, ram_addr, exp_ack, exp_ack, exp_addr);
         end
         vectors++;
         if (color_out !== pix(1, g)) begin
            miscompares++;
            $display("FAIL contention_pixel x=%0d got %h want %h", x, color_out, pix(1, g));
         end
      end
      n_req = 1'b0;
   endtask

   task automatic test_frame_start();
      int pulses = 0;
      for (int j = 0; j < 3; j++)
         cyc(0, 10, 1'b1, 1'b0);
      for (int j = 0; j < 8; j++) begin
         cyc(0, 10, 1'b1, 1'b1);
         if (frame_start === 1'b1)
            pulses++;
         vectors++;
         if (frame_start !== (j == 1)) begin
            miscompares++;
            $display("FAIL frame_start_a j=%0d got %b want %b", j, frame_start, (j == 1));
         end
`ifdef FB_STALL_CNT_EN
         if (j == 0 || j == 2) begin
            vectors++;
            if (stall_cnt !== ((j == 0) ? 16'd160 : 16'd0)) begin
               miscompares++;
               $display("FAIL stall_cnt j=%0d got %0d want %0d", j, stall_cnt, (j == 0) ? 160 : 0);
            end
         end
`endif
      end
      for (int j = 0; j < 4; j++) begin
         cyc(0, 10, 1'b1, 1'b0);
         vectors++;
         if (frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_start_low j=%0d got %b want 0", j, frame_start);
         end
      end
      for (int j = 0; j < 4; j++) begin
         cyc(0, 10, 1'b1, 1'b1);
         if (frame_start === 1'b1)
            pulses++;
         vectors++;
         if (frame_start !== (j == 1)) begin
            miscompares++;
            $display("FAIL frame_start_b j=%0d got %b want %b", j, frame_start, (j == 1));
         end
      end
      vectors++;
      if (pulses != 2) begin
         miscompares++;
         $display("FAIL frame_pulse_count got %0d want 2", pulses);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      curx    = '0;
      cury    = '0;
      hblank  = 1'b1;
      vblank  = 1'b1;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      n_req   = 1'b0;
      n_addr  = '0;
      n_data  = '0;
      test_reset();
      test_vblank_write();
      test_out_of_range();
      test_scanout();
      test_reset_midline();
      test_contention();
      test_frame_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
